service_rx_dma: RTL

// Wishbone arbiter/bridge between the servant CPU data master and servant_ram. Pushes bytes from the
// BLE UART receiver through a small FIFO into a RAM ring window without CPU involvement.

---
 rtl/service_pkg.sv | 39 +++
 rtl/service_rx_fifo.sv | 55 +++++
 rtl/service_rx_dma.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/service_pkg.sv
// Shared definitions for the service RX DMA bridge: arbiter states, status word layout
// and the TX mailbox address decoder.
package service_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CPU  = 2'd1;
    localparam logic [1:0] ST_DMA  = 2'd2;
    localparam logic [1:0] ST_TX   = 2'd3;

    localparam int STAT_CNT_LSB = 0;
    localparam int STAT_CNT_W   = 7;
    localparam int STAT_OVR_BIT = 7;
    localparam int STAT_PTR_LSB = 8;
    localparam int STAT_PTR_W   = 24;

    typedef struct packed {
        logic       hit;
        logic [1:0] ch;
    } mbox_t;

    // First matching channel wins, so a degenerate zero stride still yields one channel.
    function automatic mbox_t mbox_decode(input logic [31:0] adr,
                                          input logic [31:0] base,
                                          input logic [31:0] stride,
                                          input int          nch);
        mbox_t       res;
        logic [31:0] slot;
        res = '0;
        for (int n = 0; n < 4; n++) begin
            slot = base + stride * 32'(n);
            if (!res.hit && (n < nch) && (adr == slot)) begin
                res.hit = 1'b1;
                res.ch  = 2'(n);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/service_rx_fifo.sv
// Small synchronous FIFO buffering received UART bytes ahead of the DMA writer.
// A push into a full FIFO is still accepted when a pop happens in the same cycle.
module service_rx_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_cnt;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty   = (r_cnt == '0);
    assign o_count   = r_cnt;
    assign o_data    = r_mem[r_rd];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            r_cnt <= r_cnt + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end

endmodule

// File: rtl/service_rx_dma.sv
// Wishbone arbiter between the CPU data master and RAM, with an RX byte DMA into a ring window
// and per-channel TX mailboxes. Optional status register at ADR_UL: define SERVICE_DMA_STATUS_EN.
module service_rx_dma
    import service_pkg::*;
#(
    parameter int          BITS       = 8,
    parameter logic [31:0] ADR_LL     = 32'h00C00000,
    parameter logic [31:0] ADR_UL     = 32'h00C10000,
    parameter int          FIFO_DEPTH = 8,
    parameter int          TX_CH      = 2,
    parameter logic [31:0] TX_BASE    = 32'h00A00000,
    parameter logic [31:0] TX_STRIDE  = 32'h00100000
) (
    input  logic                  i_wb_clk,
    input  logic                  i_wb_rst_n,
    input  logic [31:0]           i_cpu_adr,
    input  logic [31:0]           i_cpu_dat,
    input  logic [3:0]            i_cpu_sel,
    input  logic                  i_cpu_we,
    input  logic                  i_cpu_cyc,
    output logic [31:0]           o_cpu_rdt,
    output logic                  o_cpu_ack,
    output logic [31:0]           o_ram_adr,
    output logic [31:0]           o_ram_dat,
    output logic [3:0]            o_ram_sel,
    output logic                  o_ram_we,
    output logic                  o_ram_cyc,
    input  logic [31:0]           i_ram_rdt,
    input  logic                  i_ram_ack,
    input  logic                  i_rx_valid,
    input  logic [BITS-1:0]       i_rx_data,
    output logic [TX_CH*BITS-1:0] o_tx_data,
    output logic [TX_CH-1:0]      o_tx_valid,
    input  logic [TX_CH-1:0]      i_tx_busy,
    output logic                  o_overrun
);

    localparam int CW = $clog2(FIFO_DEPTH);

    logic [1:0]            r_state;
    logic [31:0]           r_ram_adr;
    logic [31:0]           r_ram_dat;
    logic [3:0]            r_ram_sel;
    logic                  r_ram_we;
    logic                  r_ram_cyc;
    logic [31:0]           r_wptr;
    logic                  r_overrun;
    logic [1:0]            r_ch;
    logic                  r_tx_we;
    logic [BITS-1:0]       r_tx_hold;
    logic                  r_loc_ack;
    logic [31:0]           r_loc_rdt;
    logic [TX_CH*BITS-1:0] r_tx_data;
    logic [TX_CH-1:0]      r_tx_valid;

    logic [BITS-1:0]       w_fifo_data;
    logic                  w_full;
    logic                  w_empty;
    logic [CW:0]           w_count;
    logic                  w_pop;
    logic                  w_cpu_req;
    logic                  w_cpu_ram_ack;
    logic                  w_stat_hit;
    logic                  w_busy_sel;
    logic [7:0]            w_byte8;
    mbox_t                 w_mbox;

    service_rx_fifo #(
        .WIDTH (BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_wb_clk),
        .i_rst_n (i_wb_rst_n),
        .i_push  (i_rx_valid),
        .i_data  (i_rx_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // A locally generated ack is still visible for one cycle while the CPU drops cyc,
    // so that cycle must not be mistaken for a fresh request.
    assign w_cpu_req     = i_cpu_cyc && !r_loc_ack;
    assign w_mbox        = mbox_decode(i_cpu_adr, TX_BASE, TX_STRIDE, TX_CH);
    assign w_pop         = (r_state == ST_IDLE) && !w_cpu_req && !w_empty;
    assign w_cpu_ram_ack = (r_state == ST_CPU) && i_ram_ack;
    assign w_byte8       = 8'(w_fifo_data);

`ifdef SERVICE_DMA_STATUS_EN
    logic [STAT_CNT_W-1:0] w_cnt_sat;
    logic [31:0]           w_status;

    assign w_stat_hit = (i_cpu_adr == ADR_UL);
    assign w_cnt_sat  = (32'(w_count) > 32'd127) ? 7'h7F : 7'(w_count);

    always_comb begin
        w_status = '0;
        w_status[STAT_PTR_LSB +: STAT_PTR_W] = r_wptr[STAT_PTR_W-1:0];
        w_status[STAT_OVR_BIT]               = r_overrun;
        w_status[STAT_CNT_LSB +: STAT_CNT_W] = w_cnt_sat;
    end
`else
    assign w_stat_hit = 1'b0;
`endif

    always_comb begin
        w_busy_sel = 1'b0;
        for (int n = 0; n < TX_CH; n++) begin
            if (r_ch == 2'(n)) begin
                w_busy_sel = i_tx_busy[n];
            end
        end
    end

    assign o_cpu_ack  = w_cpu_ram_ack | r_loc_ack;
    assign o_cpu_rdt  = w_cpu_ram_ack ? i_ram_rdt : r_loc_rdt;
    assign o_ram_adr  = r_ram_adr;
    assign o_ram_dat  = r_ram_dat;
    assign o_ram_sel  = r_ram_sel;
    assign o_ram_we   = r_ram_we;
    assign o_ram_cyc  = r_ram_cyc;
    assign o_tx_data  = r_tx_data;
    assign o_tx_valid = r_tx_valid;
    assign o_overrun  = r_overrun;

    always_ff @(posedge i_wb_clk) begin
        if (!i_wb_rst_n) begin
            r_state    <= ST_IDLE;
            r_ram_adr  <= '0;
            r_ram_dat  <= '0;
            r_ram_sel  <= '0;
            r_ram_we   <= 1'b0;
            r_ram_cyc  <= 1'b0;
            r_wptr     <= ADR_LL;
            r_overrun  <= 1'b0;
            r_ch       <= '0;
            r_tx_we    <= 1'b0;
            r_tx_hold  <= '0;
            r_loc_ack  <= 1'b0;
            r_loc_rdt  <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= '0;
        end else begin
            r_loc_ack  <= 1'b0;
            r_loc_rdt  <= '0;
            r_tx_valid <= '0;
            if (i_rx_valid && w_full && !w_pop) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_cpu_req) begin
                        if (w_stat_hit) begin
                            r_loc_ack <= 1'b1;
`ifdef SERVICE_DMA_STATUS_EN
                            if (i_cpu_we) begin
                                r_overrun <= 1'b0;
                            end else begin
                                r_loc_rdt <= w_status;
                            end
`endif
                        end else if (w_mbox.hit) begin
                            r_ch      <= w_mbox.ch;
                            r_tx_we   <= i_cpu_we;
                            r_tx_hold <= i_cpu_dat[BITS-1:0];
                            r_state   <= ST_TX;
                        end else begin
                            r_ram_adr <= i_cpu_adr;
                            r_ram_dat <= i_cpu_dat;
                            r_ram_sel <= i_cpu_sel;
                            r_ram_we  <= i_cpu_we;
                            r_ram_cyc <= 1'b1;
                            r_state   <= ST_CPU;
                        end
                    end else if (!w_empty) begin
                        r_ram_adr <= {r_wptr[31:2], 2'b00};
                        r_ram_dat <= {4{w_byte8}};
                        r_ram_sel <= 4'b0001 << r_wptr[1:0];
                        r_ram_we  <= 1'b1;
                        r_ram_cyc <= 1'b1;
                        r_state   <= ST_DMA;
                    end
                end
                ST_CPU: begin
                    if (i_ram_ack) begin
                        r_ram_cyc <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_DMA: begin
                    if (i_ram_ack) begin
                        r_ram_cyc <= 1'b0;
                        r_wptr    <= (r_wptr + 32'd1 == ADR_UL) ? ADR_LL : r_wptr + 32'd1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    // Mailbox reads report busy immediately; writes hold the CPU until the channel frees.
                    if (!r_tx_we) begin
                        r_loc_ack <= 1'b1;
                        r_loc_rdt <= {31'b0, w_busy_sel};
                        r_state   <= ST_IDLE;
                    end else if (!w_busy_sel) begin
                        r_loc_ack <= 1'b1;
                        for (int n = 0; n < TX_CH; n++) begin
                            if (r_ch == 2'(n)) begin
                                r_tx_valid[n]              <= 1'b1;
                                r_tx_data[n*BITS +: BITS]  <= r_tx_hold;
                            end
                        end
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
